prbs_burst_ctrl: RTL and testbench

PRBS_BURST_CTRL -- requirements
Module: prbs_burst_ctrl

---
 rtl/prbs_burst_ctrl.sv | 178 +++++++++++++++++
 tb/tb_prbs_burst_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_burst_ctrl.sv
// PRBS burst controller: emits bursts of LFSR words over a valid/ready stream.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready_o high
// RUN   | emitting words until the counter is exhausted or aborted
// DONE  | one-cycle done_o pulse, then back to IDLE
module prbs_burst_ctrl #(
  parameter int N     = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_reseed_i,
  input  logic [N-1:0]     cmd_seed_i,
  input  logic             abort_i,
  output logic [N-1:0]     data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Maximal-length tap positions (bit k-1 set for tap k), widths 3..32.
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    m = 32'h0;
    case (w)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]      TAPS_ALL = tap_mask(N);
  localparam logic [N-1:0]     TAPS     = TAPS_ALL[N-1:0];
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Shift left, XNOR of the taps into bit 0 (all-ones is the lock-up state).
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {s[N-2:0], ~^(s & TAPS)};
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     lfsr_q, lfsr_d;
  logic [N-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             can_emit;
  logic             gen_run;
  logic [N-1:0]     seed_sel;
  logic [N-1:0]     word_nxt;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) state_d = S_RUN;
      S_RUN: begin
        if (abort_i)                            state_d = S_DONE;
        else if ((cnt_q == '0) && can_emit)     state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
  end

  // Datapath next values: the accept edge already produces the first word
  always_comb begin
    accept   = (state_q == S_IDLE) && cmd_valid_i;
    can_emit = !valid_q || data_ready_i;
    gen_run  = (state_q == S_RUN) && !abort_i && (cnt_q != '0) && can_emit;
    seed_sel = cmd_reseed_i ? ((cmd_seed_i == '1) ? '0 : cmd_seed_i) : lfsr_q;
    word_nxt = lfsr_step(accept ? seed_sel : lfsr_q);

    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (accept) begin
      if (cmd_len_i != '0) begin
        lfsr_d  = word_nxt;
        data_d  = word_nxt;
        valid_d = 1'b1;
        cnt_d   = cmd_len_i - LEN_ONE;
      end else begin
        lfsr_d  = seed_sel;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end else if (state_q == S_RUN) begin
      if (abort_i) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end else if (gen_run) begin
        lfsr_d  = word_nxt;
        data_d  = word_nxt;
        valid_d = 1'b1;
        cnt_d   = cnt_q - LEN_ONE;
      end else if (valid_q && data_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed bench for prbs_burst_ctrl with N=8, LEN_W=16.
module tb_prbs_burst_ctrl;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i;
  logic        cmd_reseed_i;
  logic [7:0]  cmd_seed_i;
  logic        abort_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  // Sequence from LFSR state 0, taps 7,5,4,3, XNOR feedback.
  logic [7:0] seq0 [0:15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A, 8'hF4,
                              8'hE8, 8'hD0, 8'hA1, 8'h43, 8'h87, 8'h0E, 8'h1C, 8'h39};

  prbs_burst_ctrl #(.N(8), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .cmd_reseed_i (cmd_reseed_i),
    .cmd_seed_i   (cmd_seed_i),
    .abort_i      (abort_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command in IDLE; returns in the cycle after accept.
  task automatic send_cmd(input logic [15:0] len, input logic reseed, input logic [7:0] seed,
                          input string tag);
    cmd_valid_i  = 1'b1;
    cmd_len_i    = len;
    cmd_reseed_i = reseed;
    cmd_seed_i   = seed;
    check_val({tag, "_acc_rdy"}, 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i  = 1'b0;
    cmd_reseed_i = 1'b0;
  endtask

  // Drive ready from rmask per cycle, compare every valid word with seq0[start+idx],
  // then check word count, done timing and the return to IDLE.
  task automatic run_burst(input int n, input int start, input logic [31:0] rmask,
                           input string tag);
    int idx;
    int last_hs;
    int done_at;
    idx = 0;
    last_hs = -1;
    done_at = -1;
    for (int c = 0; c < 64; c++) begin
      data_ready_i = (c < 32) ? rmask[c] : 1'b1;
      if (c == 0) check_val({tag, "_busy_rdy"}, 32'(cmd_ready_o), 32'd0);
      if (done_o) begin
        done_at = c;
        break;
      end
      if (data_valid_o) begin
        if (idx < n && (start + idx) < 16)
          check_val({tag, "_word"}, 32'(data_o), 32'(seq0[start+idx]));
        if (data_ready_i) begin
          idx++;
          last_hs = c;
        end
      end
      tick();
    end
    check_val({tag, "_count"}, 32'(idx), 32'(n));
    check_val({tag, "_done_at"}, 32'(done_at), (n == 0) ? 32'd1 : 32'(last_hs + 1));
    if (done_at >= 0) begin
      tick();
      check_val({tag, "_done_pulse"}, 32'(done_o), 32'd0);
      check_val({tag, "_idle_rdy"}, 32'(cmd_ready_o), 32'd1);
      check_val({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    end
    data_ready_i = 1'b1;
  endtask

  initial begin
    rst_i        = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_len_i    = 16'd0;
    cmd_reseed_i = 1'b0;
    cmd_seed_i   = 8'h00;
    abort_i      = 1'b0;
    data_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_data",  32'(data_o),       32'd0);
    check_val("rst_valid", 32'(data_valid_o), 32'd0);
    check_val("rst_done",  32'(done_o),       32'd0);
    check_val("rst_busy",  32'(busy_o),       32'd0);
    check_val("rst_rdy",   32'(cmd_ready_o),  32'd1);
    rst_i = 1'b0;
    tick();

    // basic burst, then continuation without reseed
    send_cmd(16'd6, 1'b1, 8'h00, "basic");
    run_burst(6, 0, 32'hFFFF_FFFF, "basic");
    send_cmd(16'd2, 1'b0, 8'h00, "cont");
    run_burst(2, 6, 32'hFFFF_FFFF, "cont");

    // backpressure: second word stalled for 3 cycles
    send_cmd(16'd4, 1'b1, 8'h00, "bp");
    run_burst(4, 0, 32'hFFFF_FFF1, "bp");

    // zero length, then lock-up seed
    send_cmd(16'd0, 1'b0, 8'h00, "zero");
    run_burst(0, 0, 32'hFFFF_FFFF, "zero");
    send_cmd(16'd2, 1'b1, 8'hFF, "lock");
    run_burst(2, 0, 32'hFFFF_FFFF, "lock");

    // abort after 3 words of a len-10 burst
    send_cmd(16'd10, 1'b1, 8'h00, "abt");
    for (int c = 0; c < 3; c++) begin
      check_val("abt_valid", 32'(data_valid_o), 32'd1);
      check_val("abt_word",  32'(data_o),       32'(seq0[c]));
      if (c == 2) abort_i = 1'b1;
      tick();
    end
    check_val("abt_valid_clr", 32'(data_valid_o), 32'd0);
    check_val("abt_done",      32'(done_o),       32'd1);
    tick();
    check_val("abt_idle_rdy",  32'(cmd_ready_o),  32'd1);
    check_val("abt_done_clr",  32'(done_o),       32'd0);
    // abort still high in IDLE must not block the next accept
    send_cmd(16'd3, 1'b0, 8'h00, "resume");
    abort_i = 1'b0;
    run_burst(3, 3, 32'hFFFF_FFFF, "resume");

    // reset in the middle of a burst
    send_cmd(16'd10, 1'b1, 8'h00, "mrst");
    check_val("mrst_w0", 32'(data_o), 32'(seq0[0]));
    tick();
    check_val("mrst_w1", 32'(data_o), 32'(seq0[1]));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("mrst_data",  32'(data_o),       32'd0);
    check_val("mrst_valid", 32'(data_valid_o), 32'd0);
    check_val("mrst_done",  32'(done_o),       32'd0);
    check_val("mrst_busy",  32'(busy_o),       32'd0);
    check_val("mrst_rdy",   32'(cmd_ready_o),  32'd1);
    tick();
    check_val("mrst_nodone", 32'(done_o), 32'd0);
    // LFSR was cleared, so a burst without reseed starts from 0x01
    send_cmd(16'd2, 1'b0, 8'h00, "post");
    run_burst(2, 0, 32'hFFFF_FFFF, "post");
    send_cmd(16'd1, 1'b1, 8'h00, "post0");
    run_burst(1, 0, 32'hFFFF_FFFF, "post0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
